axis_ramp_slave: RTL

- AXI4-Stream slave that consumes target values, e.g. from the register-to-stream stage that emits a beat whenever a control register changes.
- Drives a register output that slews toward the latest target by a fixed step once per prescaled tick.
- Used for slew-limited setpoints: DAC offsets, DDS phase increments, gain words.

---
 rtl/axis_ramp_pkg.sv | 19 +
 rtl/axis_ramp_tick.sv | 34 +++
 rtl/axis_ramp_slave.sv | 106 ++++++++++
 3 files changed

// File: rtl/axis_ramp_pkg.sv
// Shared types and width helpers for the AXI4-Stream ramp slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axis_ramp_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } ramp_state_t;

    // One guard bit above the data width is needed so that target-value
    // never wraps, for both unsigned and two's-complement operands.
    localparam int DIFF_GUARD_BITS = 1;

    function automatic int diff_width(input int w);
        return w + DIFF_GUARD_BITS;
    endfunction

endpackage

// File: rtl/axis_ramp_tick.sv
// Prescaler: asserts tick once every cfg_div+1 enabled cycles.
// Latency: tick is combinational from the cnt register; cnt updates each edge.
// Backpressure: none; clear restarts the period and suppresses tick that cycle.
//
// Ports: aclk/areset (sync, active-high), enable (count while high),
// clear (restart period), cfg_div (period minus 1, sampled live), tick.
module axis_ramp_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;
    logic                 reached;

    // >= rather than == so that lowering cfg_div below cnt mid-period
    // still produces a tick on the next edge instead of a long wrap.
    assign reached = (cnt >= cfg_div);
    assign tick    = enable & ~clear & reached;

    always_ff @(posedge aclk) begin
        if (areset || clear || !enable || reached) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/axis_ramp_slave.sv
// AXI4-Stream slave that slews value_out toward the last accepted target by cfg_step per tick.
// Latency: first step lands cfg_div+1 edges after the handshake, then every cfg_div+1 edges.
// Backpressure: s_axis_tready is high from the first edge out of reset; retargeting is always accepted.
//
// Ports: aclk, areset (sync, active-high), s_axis_tdata/tvalid/tready (target stream),
// cfg_step (step size, 0 = jump), cfg_div (tick period minus 1), value_out (registered),
// busy (ramping), done (one-cycle pulse when value_out reaches target).
// Build option: define AXIS_RAMP_SIGNED_EN to treat target and value_out as two's-complement.
module axis_ramp_slave
    import axis_ramp_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int STEP_WIDTH       = 16,
    parameter int DIV_WIDTH        = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [STEP_WIDTH-1:0]       cfg_step,
    input  logic [DIV_WIDTH-1:0]        cfg_div,
    output logic [AXIS_TDATA_WIDTH-1:0] value_out,
    output logic                        busy,
    output logic                        done
);

    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int DW = diff_width(AXIS_TDATA_WIDTH);

    ramp_state_t   state, state_nxt;
    logic [W-1:0]  target, target_nxt, value_nxt;
    logic          done_nxt;
    logic          hs;
    logic          tick;
    logic [DW-1:0] diff, mag, step_ext;
    logic [W-1:0]  step_w;
    logic          toward_neg;

    assign hs   = s_axis_tvalid & s_axis_tready;
    assign busy = (state == ST_RAMP);

    axis_ramp_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .aclk    (aclk),
        .areset  (areset),
        .enable  (busy),
        .clear   (hs),
        .cfg_div (cfg_div),
        .tick    (tick)
    );

`ifdef AXIS_RAMP_SIGNED_EN
    assign diff = {target[W-1], target} - {value_out[W-1], value_out};
`else
    assign diff = {1'b0, target} - {1'b0, value_out};
`endif

    // diff is a W+1 bit signed quantity; its magnitude always fits in W+1
    // unsigned bits, so comparing against the step cannot overflow.
    assign toward_neg = diff[DW-1];
    assign mag        = toward_neg ? ({DW{1'b0}} - diff) : diff;
    assign step_ext   = {{(DW-STEP_WIDTH){1'b0}}, cfg_step};
    assign step_w     = step_ext[W-1:0];

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        value_nxt  = value_out;
        done_nxt   = 1'b0;
        if (hs) begin
            // A new target pre-empts any tick on this edge, including a final one.
            target_nxt = s_axis_tdata;
            state_nxt  = ST_RAMP;
        end else if (tick) begin
            if ((cfg_step == '0) || (mag <= step_ext)) begin
                // Clamp onto the target: no overshoot and no wrap-around.
                value_nxt = target;
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
            end else if (toward_neg) begin
                value_nxt = value_out - step_w;
            end else begin
                value_nxt = value_out + step_w;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= ST_IDLE;
            target        <= '0;
            value_out     <= '0;
            done          <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            state         <= state_nxt;
            target        <= target_nxt;
            value_out     <= value_nxt;
            done          <= done_nxt;
            s_axis_tready <= 1'b1;
        end
    end

endmodule
